// File: rtl/reg_shift_sload_pout.sv
// Serial-in, parallel-out receive stage: assembles LSB-first frames into WIDTH-bit
// words and hands them off with a valid/ack handshake, flagging aborts and overruns.
module reg_shift_sload_pout #(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bit_en,
  input  logic                       ser_in,
  input  logic                       ser_busy,
  input  logic                       out_ack,
  input  logic                       ovr_clr,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_ovr,
  output logic                       frame_err,
  output logic                       rx_busy,
  output logic [$clog2(WIDTH):0]     rx_count
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;
  logic             r_err;
  logic             r_busy;
  logic [CW-1:0]    r_count;

  logic             w_bit;
  logic             w_accept;
  logic             w_abort;
  logic             w_complete;
  logic             w_take;
  logic [CW-1:0]    w_idx;
  logic [WIDTH-1:0] w_word;

  // Only a solid 1 counts as a one; X and Z from a floating line read as 0.
  assign w_bit    = (ser_in === 1'b1);
  assign w_accept = bit_en && ser_busy;
  assign w_abort  = bit_en && !ser_busy && (r_state == SHIFT);
  assign w_complete = w_accept &&
                      (((r_state == IDLE) && (WIDTH == 1)) ||
                       ((r_state == SHIFT) && (r_count == LAST)));
  // A completed word is taken unless a pending word is left unacknowledged.
  assign w_take   = !r_valid || out_ack;
  assign w_idx    = (r_state == IDLE) ? '0 : r_count;

  // NOTE: every variable is given a default at the top of always_comb so no latch is inferred.
  always_comb begin
    w_word = (r_state == IDLE) ? '0 : r_buf;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == w_idx) w_word[i] = w_bit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_err <= w_abort;

      if (w_complete) begin
        r_state <= IDLE;
        r_buf   <= '0;
        r_busy  <= 1'b0;
        r_count <= '0;
      end else if (w_accept) begin
        r_state <= SHIFT;
        r_buf   <= w_word;
        r_busy  <= 1'b1;
        r_count <= w_idx + CW'(1);
      end else if (w_abort) begin
        r_state <= IDLE;
        r_buf   <= '0;
        r_busy  <= 1'b0;
        r_count <= '0;
      end

      if (w_complete && w_take) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (out_ack && r_valid && !w_complete) begin
        r_valid <= 1'b0;
      end

      // A fresh overrun wins over a simultaneous clear.
      if (w_complete && !w_take) begin
        r_ovr <= 1'b1;
      end else if (ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_ovr   = r_ovr;
  assign frame_err = r_err;
  assign rx_busy   = r_busy;
  assign rx_count  = r_count;

endmodule

// File: tb/tb_reg_shift_sload_pout.sv
// Bench for reg_shift_sload_pout: directed frames from the test plan followed by a
// randomized run, all checked every cycle against a queue-based frame model.
module tb_reg_shift_sload_pout;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_en, ser_in, ser_busy, out_ack, ovr_clr;
  logic [W-1:0]  out_data;
  logic          out_valid, out_ovr, frame_err, rx_busy;
  logic [5:0]    rx_count;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the frame in progress plus the handshake state.
  bit            m_bits[$];
  logic [W-1:0]  m_data;
  bit            m_valid, m_ovr, m_err;

  reg_shift_sload_pout #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .ser_in(ser_in), .ser_busy(ser_busy),
    .out_ack(out_ack), .ovr_clr(ovr_clr), .out_data(out_data), .out_valid(out_valid),
    .out_ovr(out_ovr), .frame_err(frame_err), .rx_busy(rx_busy), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out_data",  out_data, m_data);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_ovr",   32'(out_ovr), 32'(m_ovr));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("rx_busy",   32'(rx_busy), 32'(m_bits.size() > 0));
    check("rx_count",  32'(rx_count), 32'(m_bits.size()));
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_data  = '0;
    m_valid = 0;
    m_ovr   = 0;
    m_err   = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then compare.
  task automatic step(input logic be, input logic si, input logic sb,
                      input logic ack, input logic clr);
    logic [W-1:0] word;
    bit           done;
    bit           overrun;
    bit_en = be; ser_in = si; ser_busy = sb; out_ack = ack; ovr_clr = clr;
    @(posedge clk);
    #1;
    done  = 0;
    word  = '0;
    m_err = 0;
    if (be && sb) begin
      m_bits.push_back(si === 1'b1);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word = word + ((W)'(m_bits[i]) << i);
        m_bits.delete();
        done = 1;
      end
    end else if (be && !sb && m_bits.size() > 0) begin
      m_bits.delete();
      m_err = 1;
    end
    overrun = done && m_valid && !ack;
    if (done) begin
      if (!m_valid || ack) begin
        m_data  = word;
        m_valid = 1;
      end
    end else if (ack && m_valid) begin
      m_valid = 0;
    end
    if (overrun) m_ovr = 1;
    else if (clr) m_ovr = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int gap,
                            input bit ack_last, input bit use_z);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = use_z ? 1'bz : word[i];
      step(1, b, 1, ack_last && (i == W - 1), 0);
      for (int g = 0; g < gap; g++) step(0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bit_en = 0; ser_in = 0; ser_busy = 0; out_ack = 0; ovr_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    idle(2);

    // Nominal frame with a strobe every fourth clock.
    send_frame(32'hA5A5_0F0F, 3, 0, 0);
    check("nominal_word", out_data, 32'hA5A5_0F0F);
    step(0, 0, 0, 1, 0);

    // Abort at the tenth strobe, then a clean frame.
    for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    check("abort_err", 32'(frame_err), 32'd1);
    idle(1);
    send_frame(32'h0000_0001, 0, 0, 0);
    check("after_abort", out_data, 32'h0000_0001);
    step(0, 0, 0, 1, 0);

    // Overrun, then clear.
    send_frame(32'h1111_1111, 1, 0, 0);
    send_frame(32'h2222_2222, 0, 0, 0);
    check("ovr_keep", out_data, 32'h1111_1111);
    check("ovr_set", 32'(out_ovr), 32'd1);
    step(0, 0, 0, 0, 1);

    // Completion colliding with an ack replaces the pending word.
    send_frame(32'hDEAD_BEEF, 0, 1, 0);
    check("collide", out_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 1, 0);

    // Floating serial line captures as zeros.
    send_frame(32'hFFFF_FFFF, 0, 0, 1);
    check("z_word", out_data, 32'h0000_0000);
    step(0, 0, 0, 1, 0);

    // Reset in the middle of a frame while a word is pending.
    send_frame(32'h1234_5678, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 reset = 1'b1;
    send_frame(32'hFFFF_FFFF, 0, 0, 0);
    check("post_reset", out_data, 32'hFFFF_FFFF);

    // Randomized traffic, including ovr_clr racing a fresh overrun.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_shift_sload_pout.md
# reg_shift_sload_pout

Serial-in, parallel-out receive stage. It sits directly downstream of the parallel-load transmit shift register and captures its LSB-first serial bit stream, one bit per bit strobe. It reassembles each frame into a WIDTH-bit word and presents the word to the calculator core with a valid/ack handshake. It also flags frames that are cut short and words that are overwritten before being consumed.

## Interface
- WIDTH, 32, number of bits per frame and width of the output word.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately.
- bit_en  input  1  one-clk-wide strobe marking a serial bit time. ser_in and ser_busy are sampled only when it is high.
- ser_in  input  1  serial data bit, LSB first. Any value other than 1 (0, X, Z) is captured as 0.
- ser_busy  input  1  frame-active indicator from the upstream transmitter.
- out_ack  input  1  consumer accepts the word; meaningful only while out_valid=1.
- ovr_clr  input  1  clears the sticky out_ovr flag.
- out_data  output  WIDTH  last completed word; bit 0 = first bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ovr  output  1  sticky overrun: a frame completed while out_valid=1 and no ack was given.
- frame_err  output  1  one-clk pulse: frame aborted before WIDTH bits.
- rx_busy  output  1  high while a frame is being assembled.
- rx_count  output  $clog2(WIDTH)+1  number of bits captured in the current frame.

## Operation
- Reset values: out_data=0, out_valid=0, out_ovr=0, frame_err=0, rx_busy=0, rx_count=0, shift buffer=0, state=IDLE.
- Two states, IDLE and SHIFT. Output holding is independent of state, so reception continues while a word is pending.
- IDLE:
  - bit_en=1 and ser_busy=1: store ser_in into buffer[0], set rx_count=1, rx_busy=1, go to SHIFT.
  - bit_en=1 with ser_busy=0: ignored.
- SHIFT, on bit_en=1 with ser_busy=1:
  - Store ser_in into buffer[rx_count] and increment rx_count.
  - If this is bit WIDTH-1 the frame is complete: transfer buffer to out_data, return to IDLE, set rx_count=0 and rx_busy=0.
- SHIFT, on bit_en=1 with ser_busy=0 (premature end): discard buffer, pulse frame_err for 1 clk, return to IDLE, set rx_count=0. out_data and out_valid are unchanged.
- SHIFT, bit_en=0: hold all state. Idle gaps of any length between strobes are legal.
- Frame completion versus the pending word:
  - out_valid=0: load out_data and set out_valid=1.
  - out_valid=1 with out_ack=1 in the same cycle: load the new word, out_valid stays 1, no overrun.
  - out_valid=1 with out_ack=0: keep the old out_data, drop the new word, set out_ovr=1.
- out_ack=1 while out_valid=1 with no completion that cycle: out_valid=0 next cycle; out_data is retained.
- out_ack while out_valid=0 has no effect.
- out_ovr is cleared only by ovr_clr or reset. If ovr_clr and a new overrun occur in the same cycle, the overrun wins and out_ovr stays 1.
- WIDTH=1 is a legal degenerate case: every accepted strobe in IDLE completes a frame, and the block never enters SHIFT.

## Timing
- All inputs are synchronous to clk. bit_en must be 1 clk wide; a strobe held high for N clks counts as N bits.
- Latency: out_valid rises 1 clk after the rising edge that samples the last bit (the edge where bit_en=1 for bit WIDTH-1).
- out_data is stable whenever out_valid=1 and changes only at a load edge.
- frame_err is high for exactly the 1 clk following the aborting strobe.
- rx_count and rx_busy update on the same edge as the sampled strobe.
- Back-to-back frames are supported: bit 0 of the next frame may be sampled on the clk immediately after completion, with zero dead cycles.
- Reset asserted mid-frame or with a word pending: all outputs go to their reset values asynchronously. The partial frame is lost, and the first strobe after release is treated as a potential bit 0.

## Test plan
- Nominal: send 0xA5A5_0F0F LSB first, bit_en every 4th clk, ser_busy high for the whole frame. Expect out_data=0xA5A50F0F, out_valid=1 one clk after the 32nd strobe, rx_count returns to 0, and frame_err and out_ovr stay 0.
- Abort: ser_busy drops at the 10th strobe. Expect a 1-clk frame_err pulse, out_valid stays 0, and a following full frame of 0x0000_0001 is received correctly.
- Overrun: receive 0x11111111 without ack, then 0x22222222. Expect out_data stays 0x11111111 and out_ovr=1. Then ovr_clr=1 gives out_ovr=0.
- Ack collision: out_ack=1 on the same clk as completion of a second word 0xDEADBEEF. Expect out_data=0xDEADBEEF, out_valid stays 1, out_ovr=0.
- Z input: ser_in=Z for every bit with ser_busy=1. Expect out_data=0x00000000 and out_valid=1.
- Reset mid-frame: pull reset low after 16 bits and release it. Expect all outputs at 0 immediately, then the next 32-bit frame 0xFFFFFFFF is captured intact.
